core_ctrl: RTL

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/core_ctrl.sv
// Debug/run controller for a small core: program loading into instruction memory,
// run/halt/single-step control, hardware breakpoint and an enabled-cycle counter.
module core_ctrl (
   input  logic       clk,
   input  logic       resetn,
   input  logic       load,
   input  logic       start,
   input  logic       stop,
   input  logic       step,
   input  logic       abort,
   input  logic       prog_valid,
   input  logic [7:0] prog_data,
   input  logic       prog_last,
   output logic       prog_ready,
   input  logic       bp_en,
   input  logic [3:0] bp_addr,
   input  logic [3:0] pc,
   output logic       core_en,
   output logic       core_resetn,
   output logic       imem_we,
   output logic [3:0] imem_waddr,
   output logic [7:0] imem_wdata,
   output logic [2:0] state,
   output logic       halted,
   output logic [7:0] cycle_cnt
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      STEP = 3'd3,
      HALT = 3'd4
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] wptr_reg, wptr_next;
   logic       bp_skip_reg, bp_skip_next;
   logic [7:0] cnt_reg, cnt_next;
   logic       crst_reg, crst_next;
   logic       we_reg, we_next;
   logic [3:0] waddr_reg, waddr_next;
   logic [7:0] wdata_reg, wdata_next;
   logic       bp_hit;
   logic       handshake;

   // bp_skip masks the breakpoint for the first cycle after a resume so the core
   // can execute the instruction it halted on.
   assign bp_hit     = bp_en & (pc == bp_addr) & ~bp_skip_reg;
   assign prog_ready = (state_reg == LOAD);
   assign handshake  = prog_ready & prog_valid;
   assign core_en    = ((state_reg == RUN) & ~bp_hit) | (state_reg == STEP);

   assign state       = state_reg;
   assign halted      = (state_reg == HALT);
   assign cycle_cnt   = cnt_reg;
   assign core_resetn = crst_reg;
   assign imem_we     = we_reg;
   assign imem_waddr  = waddr_reg;
   assign imem_wdata  = wdata_reg;

   always_comb begin
      state_next   = state_reg;
      wptr_next    = wptr_reg;
      bp_skip_next = bp_skip_reg;
      we_next      = 1'b0;
      waddr_next   = waddr_reg;
      wdata_next   = wdata_reg;
      cnt_next     = (core_en && (cnt_reg != 8'hFF)) ? cnt_reg + 8'd1 : cnt_reg;

      case (state_reg)
         IDLE: begin
            if (abort) begin
               state_next = IDLE;
            end else if (start) begin
               state_next   = RUN;
               cnt_next     = 8'd0;
               bp_skip_next = 1'b0;
            end else if (load) begin
               state_next = LOAD;
               wptr_next  = 4'd0;
            end
         end
         LOAD: begin
            if (handshake) begin
               we_next    = 1'b1;
               waddr_next = wptr_reg;
               wdata_next = prog_data;
               wptr_next  = wptr_reg + 4'd1;
               if (prog_last || (wptr_reg == 4'd15))
                  state_next = IDLE;
            end
            if (abort)
               state_next = IDLE;
         end
         RUN: begin
            bp_skip_next = 1'b0;
            if (abort)
               state_next = IDLE;
            else if (stop || bp_hit)
               state_next = HALT;
         end
         HALT: begin
            if (abort) begin
               state_next = IDLE;
            end else if (start) begin
               state_next   = RUN;
               bp_skip_next = 1'b1;
            end else if (step) begin
               state_next   = STEP;
               bp_skip_next = 1'b1;
            end
         end
         STEP: begin
            state_next = abort ? IDLE : HALT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      crst_next = (state_next == RUN) || (state_next == STEP) || (state_next == HALT);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         wptr_reg    <= 4'd0;
         bp_skip_reg <= 1'b0;
         cnt_reg     <= 8'd0;
         crst_reg    <= 1'b0;
         we_reg      <= 1'b0;
         waddr_reg   <= 4'd0;
         wdata_reg   <= 8'd0;
      end else begin
         state_reg   <= state_next;
         wptr_reg    <= wptr_next;
         bp_skip_reg <= bp_skip_next;
         cnt_reg     <= cnt_next;
         crst_reg    <= crst_next;
         we_reg      <= we_next;
         waddr_reg   <= waddr_next;
         wdata_reg   <= wdata_next;
      end
   end

endmodule
